// File: rtl/game_pkg.sv
// Shared frame geometry, palette defaults and pixel-pipeline types for the game renderer.
// No logic of its own; no latency or backpressure.
// Consumers import game_pkg::*.
package game_pkg;

    localparam int         H_RES_DEF    = 640;
    localparam int         V_RES_DEF    = 480;
    localparam logic [3:0] TRANSP_DEF   = 4'h0;
    localparam logic [3:0] BG_IDX_DEF   = 4'h1;
    localparam int         DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } fw_state_t;

    // One in-flight pixel: scan coordinates plus dino/obstacle coverage.
    typedef struct packed {
        logic       vld;
        logic [9:0] x;
        logic [9:0] y;
        logic       a_on;
        logic       b_on;
    } pix_t;

    function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y,
                                             input int h);
        return 19'(y) * 19'(h) + 19'(x);
    endfunction

endpackage

// File: rtl/pixel_pipe.sv
// Delay line carrying issued pixel coordinates, coverage flags and valid to the ROM data.
// Latency: 2 cycles, matching the sprite ROM read latency.
// Backpressure: none; one pixel enters and one leaves every cycle.
module pixel_pipe (
    input  logic       Clk50,
    input  logic       Reset,
    input  logic       s0_vld,
    input  logic [9:0] s0_x,
    input  logic [9:0] s0_y,
    input  logic       s0_a_on,
    input  logic       s0_b_on,
    output logic       s2_vld,
    output logic [9:0] s2_x,
    output logic [9:0] s2_y,
    output logic       s2_a_on,
    output logic       s2_b_on
);
    import game_pkg::*;

    pix_t s1, s2;

    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= '{vld: s0_vld, x: s0_x, y: s0_y, a_on: s0_a_on, b_on: s0_b_on};
            s2 <= s1;
        end
    end

    assign s2_vld  = s2.vld;
    assign s2_x    = s2.x;
    assign s2_y    = s2.y;
    assign s2_a_on = s2.a_on;
    assign s2_b_on = s2.b_on;

endmodule

// File: rtl/frame_writer.sv
// Scans the screen, fetches dino/obstacle sprite pixels, composites them into the frame buffer.
// Latency: 3 cycles from pixel issue to fb write; frame_done 4 cycles after the last issue.
// Backpressure: none; frame buffer must accept one write per cycle while busy.
module frame_writer #(
    parameter int         H_RES  = game_pkg::H_RES_DEF,
    parameter int         V_RES  = game_pkg::V_RES_DEF,
    parameter logic [3:0] TRANSP = game_pkg::TRANSP_DEF,
    parameter logic [3:0] BG_IDX = game_pkg::BG_IDX_DEF
) (
    input  logic        Clk50,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        Restart,
    input  logic        dino_on_wr,
    input  logic        cactus_on_wr,
    input  logic        pterosaur_on_wr,
    input  logic [17:0] dino_addr,
    input  logic [17:0] cactus_addr,
    input  logic [17:0] ptero_addr,
    output logic [9:0]  WriteX,
    output logic [9:0]  WriteY,
    output logic [17:0] rom_addr_a,
    output logic [17:0] rom_addr_b,
    input  logic [3:0]  rom_data_a,
    input  logic [3:0]  rom_data_b,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [3:0]  fb_data,
    output logic        busy,
    output logic        frame_done,
    output logic        Dead
);
    import game_pkg::*;

    localparam logic [9:0] X_LAST    = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_RES - 1);
    localparam logic [1:0] DRAIN_END = 2'(DRAIN_CYCLES - 1);

    fw_state_t  state, state_nxt;
    logic [1:0] drain_cnt;
    logic       scan;
    logic       last_pix;
    logic       obst_on;

    logic       s2_vld, s2_a_on, s2_b_on;
    logic [9:0] s2_x, s2_y;
    logic       a_op, b_op;

    assign scan     = (state == SCAN);
    assign last_pix = scan && (WriteX == X_LAST) && (WriteY == Y_LAST);

    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = SCAN;
            SCAN:    if (last_pix) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_END) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Coordinates sit at (0,0) outside SCAN so a new frame always starts at the origin.
    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) begin
            WriteX    <= '0;
            WriteY    <= '0;
            drain_cnt <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (scan && !last_pix) begin
                if (WriteX == X_LAST) begin
                    WriteX <= '0;
                    WriteY <= WriteY + 10'd1;
                end else begin
                    WriteX <= WriteX + 10'd1;
                end
            end else begin
                WriteX <= '0;
                WriteY <= '0;
            end
        end
    end

    assign busy       = (state == SCAN) || (state == DRAIN);
    assign frame_done = (state == DONE);

    // Pterosaur wins over cactus when both cover the pixel.
    assign obst_on = pterosaur_on_wr || cactus_on_wr;

    always_comb begin
        rom_addr_a = '0;
        rom_addr_b = '0;
        if (scan && dino_on_wr)           rom_addr_a = dino_addr;
        if (scan && pterosaur_on_wr)      rom_addr_b = ptero_addr;
        else if (scan && cactus_on_wr)    rom_addr_b = cactus_addr;
    end

    pixel_pipe u_pipe (
        .Clk50   (Clk50),
        .Reset   (Reset),
        .s0_vld  (scan),
        .s0_x    (WriteX),
        .s0_y    (WriteY),
        .s0_a_on (dino_on_wr),
        .s0_b_on (obst_on),
        .s2_vld  (s2_vld),
        .s2_x    (s2_x),
        .s2_y    (s2_y),
        .s2_a_on (s2_a_on),
        .s2_b_on (s2_b_on)
    );

    assign a_op = s2_a_on && (rom_data_a != TRANSP);
    assign b_op = s2_b_on && (rom_data_b != TRANSP);

    always_ff @(posedge Clk50 or negedge Reset) begin
        if (!Reset) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            Dead    <= 1'b0;
        end else begin
            fb_we <= s2_vld;
            if (s2_vld) begin
                fb_addr <= pix_addr(s2_x, s2_y, H_RES);
                fb_data <= a_op ? rom_data_a : (b_op ? rom_data_b : BG_IDX);
            end
            // A collision in the same cycle as Restart keeps Dead set.
            Dead <= (s2_vld && a_op && b_op) || (Dead && !Restart);
        end
    end

endmodule
